// File: rtl/cnt_pkg.sv
// Shared definitions for the synchronous up/down counter: direction encodings
// and the load-clamp helper used by both the design and its reference model.
package cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // A load value outside the count range is pulled down to the top of the range.
    function automatic longint unsigned cnt_clamp(input longint unsigned value,
                                                  input longint unsigned modulus);
        return (value >= modulus) ? (modulus - 64'd1) : value;
    endfunction

endpackage

// File: rtl/sync_jk_cell.sv
// One counter bit: a JK flip-flop on the falling clock edge with a synchronous
// clear that forces the bit to its reset value.
module sync_jk_cell (
    input  logic clk,
    input  logic clr,
    input  logic rst_bit,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(negedge clk) begin
        if (clr) begin
            q <= rst_bit;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/sync_updn_counter.sv
// Parametrised synchronous up/down counter with load, terminal count and wrap pulse.
// Define SYNC_CNT_SAT_EN to make the counter saturate at its limits instead of wrapping.
module sync_updn_counter
    import cnt_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16,
    parameter longint unsigned  RST_VAL = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] o,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST_BITS = WIDTH'(RST_VAL);

    // Illegal configurations are reported during elaboration.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("sync_updn_counter: WIDTH must be in 2..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("sync_updn_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RST_VAL >= MODULUS) begin : g_bad_rst
        $error("sync_updn_counter: RST_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] nxt;
    logic             at_max;
    logic             at_min;

    assign at_max = (o == MAX_VAL);
    assign at_min = (o == '0);
    assign tc     = en & (((up == CNT_UP) & at_max) | ((up == CNT_DN) & at_min));

    // clr is handled inside the cells, so only load/count/hold shape nxt.
    always_comb begin
        nxt = o;
        if (load) begin
            nxt = WIDTH'(cnt_clamp(64'(d), MODULUS));
        end else if (en) begin
            if (up == CNT_UP) begin
`ifdef SYNC_CNT_SAT_EN
                nxt = at_max ? o : o + WIDTH'(1);
`else
                nxt = at_max ? '0 : o + WIDTH'(1);
`endif
            end else begin
`ifdef SYNC_CNT_SAT_EN
                nxt = at_min ? o : o - WIDTH'(1);
`else
                nxt = at_min ? MAX_VAL : o - WIDTH'(1);
`endif
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sync_jk_cell u_cell (
            .clk     (clk),
            .clr     (clr),
            .rst_bit (RST_BITS[i]),
            .j       (nxt[i]),
            .k       (~nxt[i]),
            .q       (o[i])
        );
    end

`ifdef SYNC_CNT_SAT_EN
    assign wrap = 1'b0;
`else
    // A terminal reached while counting (not loading or clearing) is a wrap.
    always_ff @(negedge clk) begin
        if (clr) begin
            wrap <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
        end
    end
`endif

endmodule

// File: tb/tb_sync_updn_counter.sv
// Self-checking bench for sync_updn_counter: directed sequences plus random
// stimulus compared against an arithmetic reference model.
module tb_sync_updn_counter;
    import cnt_pkg::*;

`ifdef SYNC_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- DUT signals ----------------
    logic       a_clr, a_en, a_up, a_load, a_tc, a_wrap;
    logic [3:0] a_d, a_o;
    logic       m_clr, m_en, m_up, m_load, m_tc, m_wrap;
    logic [3:0] m_d, m_o;
    logic       c_clr, c_en, c_up, c0_tc, c1_tc, c0_wrap, c1_wrap;
    logic [3:0] c_d, c0_o, c1_o;
    logic       c_load;

    sync_updn_counter #(.WIDTH(4), .MODULUS(64'd16), .RST_VAL(64'd0)) u_dut (
        .clk(clk), .clr(a_clr), .en(a_en), .up(a_up), .load(a_load), .d(a_d),
        .o(a_o), .tc(a_tc), .wrap(a_wrap)
    );

    sync_updn_counter #(.WIDTH(4), .MODULUS(64'd10), .RST_VAL(64'd3)) u_m10 (
        .clk(clk), .clr(m_clr), .en(m_en), .up(m_up), .load(m_load), .d(m_d),
        .o(m_o), .tc(m_tc), .wrap(m_wrap)
    );

    sync_updn_counter #(.WIDTH(4), .MODULUS(64'd16), .RST_VAL(64'd0)) u_c0 (
        .clk(clk), .clr(c_clr), .en(c_en), .up(c_up), .load(c_load), .d(c_d),
        .o(c0_o), .tc(c0_tc), .wrap(c0_wrap)
    );

    sync_updn_counter #(.WIDTH(4), .MODULUS(64'd16), .RST_VAL(64'd0)) u_c1 (
        .clk(clk), .clr(c_clr), .en(c0_tc), .up(c_up), .load(c_load), .d(c_d),
        .o(c1_o), .tc(c1_tc), .wrap(c1_wrap)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_tc(input int cnt, input int mod, input bit e, input bit u);
        return e && (u ? (cnt == mod - 1) : (cnt == 0));
    endfunction

    function automatic void model_next(input int cnt, input int mod, input int rstv,
                                       input bit c, input bit l, input int dv,
                                       input bit e, input bit u,
                                       output int nxt, output bit wr);
        nxt = cnt;
        wr  = 1'b0;
        if (c) begin
            nxt = rstv;
        end else if (l) begin
            nxt = int'(cnt_clamp(longint'(dv), longint'(mod)));
        end else if (e) begin
            if (u) begin
                if (cnt + 1 >= mod) begin
                    nxt = SAT ? cnt : 0;
                    wr  = !SAT;
                end else begin
                    nxt = cnt + 1;
                end
            end else begin
                if (cnt - 1 < 0) begin
                    nxt = SAT ? cnt : mod - 1;
                    wr  = !SAT;
                end else begin
                    nxt = cnt - 1;
                end
            end
        end
    endfunction

    int a_cnt = 0, m_cnt = 0, c0_cnt = 0, c1_cnt = 0;
    bit a_wr, m_wr, c0_wr, c1_wr;

    // ---------------- drivers (called right after a rising edge) ----------------
    task automatic a_step(input bit c, input bit l, input int dv, input bit e, input bit u);
        a_clr = c; a_load = l; a_d = 4'(dv); a_en = e; a_up = u;
        #1;
        check("a_tc", a_tc, model_tc(a_cnt, 16, e, u));
        model_next(a_cnt, 16, 0, c, l, dv, e, u, a_cnt, a_wr);
        @(posedge clk);
        check("a_o", a_o, a_cnt);
        check("a_wrap", a_wrap, a_wr);
    endtask

    task automatic m_step(input bit c, input bit l, input int dv, input bit e, input bit u);
        m_clr = c; m_load = l; m_d = 4'(dv); m_en = e; m_up = u;
        #1;
        check("m_tc", m_tc, model_tc(m_cnt, 10, e, u));
        model_next(m_cnt, 10, 3, c, l, dv, e, u, m_cnt, m_wr);
        @(posedge clk);
        check("m_o", m_o, m_cnt);
        check("m_wrap", m_wrap, m_wr);
    endtask

    task automatic c_step(input bit c);
        bit t0;
        c_clr = c;
        #1;
        t0 = model_tc(c0_cnt, 16, 1'b1, 1'b1);
        check("c0_tc", c0_tc, t0);
        model_next(c1_cnt, 16, 0, c, 1'b0, 0, t0, 1'b1, c1_cnt, c1_wr);
        model_next(c0_cnt, 16, 0, c, 1'b0, 0, 1'b1, 1'b1, c0_cnt, c0_wr);
        @(posedge clk);
        check("c0_o", c0_o, c0_cnt);
        check("c1_o", c1_o, c1_cnt);
    endtask

    // ---------------- stimulus ----------------
    int wrap_seen;
    int exp_down[5] = '{2, 1, 0, 9, 8};
    int exp_flip[4] = '{8, 7, 8, 7};

    initial begin
        a_clr = 1'b1; a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_d = '0;
        m_clr = 1'b1; m_en = 1'b0; m_up = 1'b1; m_load = 1'b0; m_d = '0;
        c_clr = 1'b1; c_en = 1'b1; c_up = 1'b1; c_load = 1'b0; c_d = '0;
        @(posedge clk);

        // Reset and full up-count through rollover
        a_step(1, 0, 0, 0, 1);
        a_step(1, 0, 0, 0, 1);
        check("rst_o", a_o, 0);
        check("rst_wrap", a_wrap, 0);
        wrap_seen = 0;
        for (int i = 0; i < 16; i++) begin
            a_step(0, 0, 0, 1, 1);
            wrap_seen += int'(a_wrap);
        end
        check("up_wrap_count", wrap_seen, SAT ? 0 : 1);

`ifdef SYNC_CNT_SAT_EN
        a_step(0, 1, 15, 0, 1);
        for (int i = 0; i < 3; i++) begin
            a_step(0, 0, 0, 1, 1);
            check("sat_hi_o", a_o, 15);
            check("sat_hi_wrap", a_wrap, 0);
        end
        a_step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            a_step(0, 0, 0, 1, 0);
            check("sat_lo_o", a_o, 0);
        end
`else
        check("up_end_o", a_o, 0);
`endif

        for (int i = 0; i < 300; i++) begin
            a_step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)));
        end

        // Modulo-10 instance: down count, clamp, priority, direction flip, hold
        m_step(1, 0, 0, 0, 1);
        m_step(1, 0, 0, 0, 1);
        check("m_rst_o", m_o, 3);
        m_step(0, 1, 3, 0, 0);
        wrap_seen = 0;
        for (int i = 0; i < 5; i++) begin
            m_step(0, 0, 0, 1, 0);
            wrap_seen += int'(m_wrap);
`ifndef SYNC_CNT_SAT_EN
            check("m_down_o", m_o, exp_down[i]);
`endif
        end
        check("m_down_wrap_count", wrap_seen, SAT ? 0 : 1);
        m_step(0, 1, 12, 0, 1);
        check("m_clamp_o", m_o, 9);
        m_step(0, 1, 5, 1, 1);
        check("m_load_over_en", m_o, 5);
        m_step(1, 1, 5, 1, 1);
        check("m_clr_over_load", m_o, 3);
        m_step(0, 1, 7, 0, 1);
        for (int i = 0; i < 4; i++) begin
            m_step(0, 0, 0, 1, (i % 2 == 0));
            check("m_flip_o", m_o, exp_flip[i]);
        end
        for (int i = 0; i < 3; i++) begin
            m_step(0, 0, 0, 0, 1);
            check("m_hold_o", m_o, 7);
            check("m_hold_tc", m_tc, 0);
        end
        for (int i = 0; i < 300; i++) begin
            m_step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)));
        end

        // Two-stage cascade through tc
        c_step(1);
        c_step(1);
        for (int i = 0; i < 16; i++) c_step(0);
`ifndef SYNC_CNT_SAT_EN
        check("cascade_16", {c1_o, c0_o}, {4'd1, 4'd0});
`endif
        for (int i = 0; i < 40; i++) c_step(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
